// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: occupancy states, the
// default bubble word and the field layout of the M/W payload.
package pipe_pkg;

  localparam int PAYLOAD_W = 161;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  // All-zero decodes as sll $0,$0,0, so an empty stage looks like a nop.
  localparam logic [PAYLOAD_W-1:0] NOP_WORD = '0;

  localparam int PC_LSB     = 0;
  localparam int INSTR_LSB  = 32;
  localparam int ALUANS_LSB = 64;
  localparam int DMRD_LSB   = 96;
  localparam int SPARE_LSB  = 128;
  localparam int BJUMP_BIT  = 160;

  function automatic logic [PAYLOAD_W-1:0] pack_mw(
    input logic [31:0] pc,
    input logic [31:0] instr,
    input logic [31:0] alu_ans,
    input logic [31:0] dm_rd,
    input logic        b_jump
  );
    logic [PAYLOAD_W-1:0] word;
    word = '0;
    word[PC_LSB     +: 32] = pc;
    word[INSTR_LSB  +: 32] = instr;
    word[ALUANS_LSB +: 32] = alu_ans;
    word[DMRD_LSB   +: 32] = dm_rd;
    word[BJUMP_BIT]        = b_jump;
    return word;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register of the skid stage: loadable, and clearable back to the
// bubble word so that an emptied slot never exposes stale payload.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = PAYLOAD_W,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= BUBBLE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage with a two-entry skid buffer, a registered in_ready,
// flush support and a saturating counter of entries discarded by flush.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = PAYLOAD_W,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [15:0]      drop_cnt
);

  occ_state_e       state;
  occ_state_e       state_next;
  logic             in_fire;
  logic             out_fire;
  logic             main_load;
  logic             main_from_skid;
  logic             main_clear;
  logic             skid_load;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [2:0]       drop_inc;
  logic [16:0]      drop_sum;

  assign out_valid = (state != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = state;
  assign out_data  = main_q;

  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          state_next = ST_ONE;
          main_load  = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          state_next = ST_FULL;
          skid_load  = 1'b1;
        end else if (out_fire) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_next     = ST_ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
    if (flush) begin
      state_next = ST_EMPTY;
    end
  end

  // Clearing main whenever the stage drains keeps out_data at BUBBLE in EMPTY.
  assign main_clear = flush | (state_next == ST_EMPTY);
  assign main_d     = main_from_skid ? skid_q : in_data;

  pipe_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_main (
    .clk   (clk),
    .reset (reset),
    .clear (main_clear),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_skid (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .load  (skid_load),
    .d     (in_data),
    .q     (skid_q)
  );

  // Held entries, minus one leaving downstream, plus one arriving this cycle.
  assign drop_inc = {1'b0, state} + {2'b00, in_fire} - {2'b00, out_fire};
  assign drop_sum = {1'b0, drop_cnt} + {14'd0, drop_inc};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
      drop_cnt <= 16'd0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != ST_FULL);
      if (flush) begin
        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
  end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised, elastic pipeline stage register for the five-stage CPU. It replaces the fixed per-boundary stage registers (F/D, D/E, E/M, M/W) with one generic block. The block carries an opaque payload (PC, instruction, ALU result, DM read data, jump flag, etc.) across a valid/ready handshake and supports flush and bubble insertion. A two-entry skid buffer gives full throughput while keeping `in_ready` registered, which breaks the combinational stall path that runs back through the hazard unit.

## Interface
- `WIDTH`, default 161: payload width in bits (32 PC + 32 Instr + 32 ALUAns + 32 DMRD + 32 spare + 1 b_jump).
- `BUBBLE`, default `{WIDTH{1'b0}}`: value presented on `out_data` whenever no valid entry exists. All-zero decodes as `sll $0,$0,0`, i.e. a nop.
- `clk`, in, 1: clock. All state updates on its rising edge.
- `reset`, in, 1: reset, synchronous, active-high.
- `flush`, in, 1: synchronous, active-high. Discards all held entries and any same-cycle input.
- `in_valid`, in, 1: upstream offers `in_data`.
- `in_ready`, out, 1: stage can accept. Registered; no combinational path from `out_ready`.
- `in_data`, in, `WIDTH`: upstream payload.
- `out_valid`, out, 1: `out_data` holds a real entry.
- `out_ready`, in, 1: downstream accepts this cycle.
- `out_data`, out, `WIDTH`: head entry, or `BUBBLE` when `out_valid` = 0.
- `occupancy`, out, 2: number of held entries (0..2).
- `drop_cnt`, out, 16: count of valid entries discarded by `flush`. Saturating.

## Operation
- Transfer rules: input fire = `in_valid & in_ready`; output fire = `out_valid & out_ready`.
- Two storage slots. `main` drives `out_data`; `skid` holds overflow.
- State is encoded as occupancy, with three states:
  - EMPTY (0): input fire → ONE (main ← `in_data`).
  - ONE (1):
    - input fire & output fire → ONE (main ← `in_data`).
    - input fire & no output fire → FULL (skid ← `in_data`).
    - output fire & no input fire → EMPTY.
    - otherwise hold.
  - FULL (2): `in_ready` = 0.
    - output fire → ONE (main ← skid).
    - otherwise hold.
- `in_ready` = (next state ≠ FULL), registered.
- Order is strictly FIFO. No entry is duplicated or lost except by flush or reset.
- Flush:
  - Next state is EMPTY; both slots are forced to `BUBBLE`.
  - The same-cycle input is dropped even if `in_valid` & `in_ready`.
  - A same-cycle output fire still counts as delivered downstream.
- `drop_cnt`:
  - On flush, it increases by the number of entries held (0, 1 or 2) minus 1 if an output fire occurred that cycle, plus 1 if an input fire occurred that cycle.
  - It saturates at 16'hFFFF.
  - It is cleared only by reset.
- Reset has priority over flush. Reset clears `drop_cnt`; flush does not.
- `out_data` equals `BUBBLE` in EMPTY. It is never stale payload.

## Timing
- Reset values: `out_valid` = 0, `out_data` = `BUBBLE`, `in_ready` = 1, `occupancy` = 0, `drop_cnt` = 0.
- Latency: input fire in cycle N → `out_valid` = 1 with that data in cycle N+1.
- Throughput: one entry per cycle while `out_ready` = 1.
- Stall response: `out_ready` falling in cycle N → `in_ready` falls at N+1 at the latest. At most one extra entry is absorbed, into skid.
- Stall release: `out_ready` returning in FULL → `in_ready` = 1 in the next cycle.
- Flush in cycle N → `out_valid` = 0 and `in_ready` = 1 at N+1.
- Reset asserted mid-stream → all outputs take reset values the following cycle, regardless of handshake.

## Structure
- Shared package `pipe_pkg` holds:
  - Occupancy state constants `ST_EMPTY`, `ST_ONE`, `ST_FULL`.
  - Default `BUBBLE` (`NOP_WORD`).
  - Field offsets used to pack and unpack the M/W payload.
- Natural sub-module: `pipe_slot`, a `WIDTH`-bit register with load enable and a clear-to-`BUBBLE` input. It is instantiated twice (main, skid). FSM, counter and handshake logic stay in the top.

## Test plan
- Streaming: `out_ready` = 1; push 0x1..0x8 on consecutive cycles → outputs 0x1..0x8 on consecutive cycles, one cycle late; `occupancy` never exceeds 1.
- Backpressure: push 0xA, 0xB, 0xC while `out_ready` = 0 → 0xA in main, 0xB in skid, `in_ready` = 0, 0xC held by upstream. Raise `out_ready` → outputs 0xA, 0xB, 0xC in order with no loss.
- Flush when FULL (0xA, 0xB held) with `in_valid` = 1 and `out_ready` = 0 → next cycle `out_valid` = 0, `out_data` = `BUBBLE`, `drop_cnt` = 2, `in_ready` = 1.
- Flush with simultaneous output fire in ONE (main = 0x5) and input fire (0x6) → 0x5 is delivered, 0x6 is dropped, `drop_cnt` increases by 1.
- Reset mid-stream at FULL with `drop_cnt` = 3 → next cycle all reset values hold, including `drop_cnt` = 0.
- Saturation: preload `drop_cnt` = 0xFFFE, then flush FULL → `drop_cnt` = 0xFFFF, with no wrap.
